// File: rtl/bnn_pkg.sv
// ============================================================================
//  bnn_pkg -- shared types and default sizes for the BNN weight scheduler
//  Revision: 1.0
// ============================================================================
`default_nettype none

package bnn_pkg;

    localparam int unsigned N_CLASS         = 10;
    localparam int unsigned CONV1_BITS_DEF  = 18;
    localparam int unsigned CONV2_BITS_DEF  = 288;
    localparam int unsigned FC_DEPTH_DEF    = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FC   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bnn_addr_ctr.sv
// ============================================================================
//  bnn_addr_ctr -- saturating ROM address counter with clear and last flag
//  Revision: 1.0
// ============================================================================
`default_nettype none

module bnn_addr_ctr #(
    parameter int unsigned W    = 9,
    parameter int unsigned LAST = 305
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         last
);

    localparam logic [W-1:0] LAST_V = W'(LAST);

    // Holds at LAST so an address past the end is never produced.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == LAST_V);

endmodule

`default_nettype wire

// File: rtl/bnn_weight_sched.sv
// ============================================================================
//  bnn_weight_sched -- streams conv/FC weights from ROM into a BNN accelerator
//  Optional sticky protocol-error flag: define BNN_WSCHED_ERR_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module bnn_weight_sched
    import bnn_pkg::*;
#(
    parameter int unsigned CONV1_BITS = CONV1_BITS_DEF,
    parameter int unsigned CONV2_BITS = CONV2_BITS_DEF,
    parameter int unsigned FC_DEPTH   = FC_DEPTH_DEF,
    parameter int unsigned CAW        = 9,
    parameter int unsigned FAW        = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               weight_en_0,
    input  logic               weight_en_1,
    input  logic               fc_ivalid,
    output logic               conv_mem_rd,
    output logic [CAW-1:0]     conv_mem_addr,
    input  logic               conv_mem_rdata,
    output logic               fc_mem_rd,
    output logic [FAW-1:0]     fc_mem_addr,
    input  logic [N_CLASS-1:0] fc_mem_rdata,
    output logic               weight_conv_in,
    output logic [N_CLASS-1:0] weight_fc_in,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t state, state_nxt;

    logic               req_conv;
    logic               conv_rd;
    logic               fc_rd;
    logic               start_acc;
    logic               conv_last;
    logic               fc_last;
    logic [CAW-1:0]     conv_cnt;
    logic [FAW-1:0]     fc_cnt;
    logic               conv_rd_q;
    logic               conv_bit_q;
    logic               fc_rd_q;
    logic [N_CLASS-1:0] fc_word_q;

    assign req_conv  = weight_en_0 | weight_en_1;
    assign conv_rd   = (state == ST_CONV) && req_conv;
    assign fc_rd     = (state == ST_FC) && fc_ivalid;
    assign start_acc = (state == ST_IDLE) && start;

    bnn_addr_ctr #(
        .W    (CAW),
        .LAST (CONV1_BITS + CONV2_BITS - 1)
    ) u_conv_ctr (
        .clk  (clk),
        .rstn (rstn),
        .clr  (start_acc),
        .inc  (conv_rd),
        .cnt  (conv_cnt),
        .last (conv_last)
    );

    bnn_addr_ctr #(
        .W    (FAW),
        .LAST (FC_DEPTH - 1)
    ) u_fc_ctr (
        .clk  (clk),
        .rstn (rstn),
        .clr  (start_acc),
        .inc  (fc_rd),
        .cnt  (fc_cnt),
        .last (fc_last)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start)               state_nxt = ST_CONV;
            ST_CONV: if (conv_rd && conv_last) state_nxt = ST_FC;
            ST_FC:   if (fc_rd && fc_last)     state_nxt = ST_FIN;
            ST_FIN:                            state_nxt = ST_IDLE;
            default:                           state_nxt = ST_IDLE;
        endcase
    end

    // ROM data lands one cycle after the strobe; pass it straight through
    // in that cycle and keep a copy so the value holds until the next read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            conv_rd_q  <= 1'b0;
            conv_bit_q <= 1'b0;
            fc_rd_q    <= 1'b0;
            fc_word_q  <= '0;
        end else begin
            conv_rd_q <= conv_rd;
            fc_rd_q   <= fc_rd;
            if (conv_rd_q) conv_bit_q <= conv_mem_rdata;
            if (fc_rd_q)   fc_word_q  <= fc_mem_rdata;
        end
    end

    assign weight_conv_in = conv_rd_q ? conv_mem_rdata : conv_bit_q;
    assign weight_fc_in   = fc_rd_q   ? fc_mem_rdata   : fc_word_q;

    assign conv_mem_rd   = conv_rd;
    assign conv_mem_addr = conv_cnt;
    assign fc_mem_rd     = fc_rd;
    assign fc_mem_addr   = fc_cnt;
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_FIN);

`ifdef BNN_WSCHED_ERR_EN
    logic viol;
    logic err_q;

    assign viol = (req_conv && (state != ST_CONV)) || (fc_ivalid && (state != ST_FC));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (start_acc ? 1'b0 : err_q) | viol;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bnn_weight_sched.sv
// ============================================================================
//  tb_bnn_weight_sched -- directed scoreboard bench for bnn_weight_sched
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bnn_weight_sched;
    import bnn_pkg::*;

    localparam int CAW = 9;
    localparam int FAW = 8;
    localparam int NCONV = 306;
    localparam int NFC = 256;
`ifdef BNN_WSCHED_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rstn;
    logic               start;
    logic               we0;
    logic               we1;
    logic               fc_ivalid;
    logic               conv_mem_rd;
    logic [CAW-1:0]     conv_mem_addr;
    logic               conv_mem_rdata = 1'b0;
    logic               fc_mem_rd;
    logic [FAW-1:0]     fc_mem_addr;
    logic [N_CLASS-1:0] fc_mem_rdata = '0;
    logic               weight_conv_in;
    logic [N_CLASS-1:0] weight_fc_in;
    logic               busy;
    logic               done;
    logic               err;

    int vectors     = 0;
    int miscompares = 0;
    int sb[$];

    bnn_weight_sched dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .weight_en_0    (we0),
        .weight_en_1    (we1),
        .fc_ivalid      (fc_ivalid),
        .conv_mem_rd    (conv_mem_rd),
        .conv_mem_addr  (conv_mem_addr),
        .conv_mem_rdata (conv_mem_rdata),
        .fc_mem_rd      (fc_mem_rd),
        .fc_mem_addr    (fc_mem_addr),
        .fc_mem_rdata   (fc_mem_rdata),
        .weight_conv_in (weight_conv_in),
        .weight_fc_in   (weight_fc_in),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    // ROM models: conv1 region reads 1, conv2 reads 0; FC word = address.
    always @(posedge clk) begin
        if (conv_mem_rd) conv_mem_rdata <= (conv_mem_addr < 18);
        if (fc_mem_rd)   fc_mem_rdata   <= 10'(fc_mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] obs);
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
        end else begin
            chk(tag, obs, sb.pop_front());
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_conv_mem_rd", conv_mem_rd, 0);
        chk("rst_fc_mem_rd", fc_mem_rd, 0);
        chk("rst_weight_conv_in", weight_conv_in, 0);
        chk("rst_weight_fc_in", weight_fc_in, 0);
        chk("rst_conv_mem_addr", conv_mem_addr, 0);
        chk("rst_fc_mem_addr", fc_mem_addr, 0);
    endtask

    task automatic conv_beat(input logic e0, input logic e1, input int addr);
        we0 = e0;
        we1 = e1;
        @(negedge clk);
        chk("conv_mem_rd", conv_mem_rd, 1);
        chk("conv_mem_addr", conv_mem_addr, addr);
        sb.push_back((addr < 18) ? 1 : 0);
        @(posedge clk); #1;
        we0 = 1'b0;
        we1 = 1'b0;
        chk_pop("weight_conv_in", weight_conv_in);
    endtask

    task automatic fc_beat(input int addr);
        fc_ivalid = 1'b1;
        @(negedge clk);
        chk("fc_mem_rd", fc_mem_rd, 1);
        chk("fc_mem_addr", fc_mem_addr, addr);
        chk("fc_done_low", done, 0);
        sb.push_back(addr & 10'h3ff);
        @(posedge clk); #1;
        fc_ivalid = 1'b0;
        chk_pop("weight_fc_in", weight_fc_in);
    endtask

    task automatic start_load();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_err", err, 0);
    endtask

    task automatic conv_load();
        for (int i = 0; i < 4; i++)      conv_beat(1'b1, 1'b1, i);
        for (int i = 4; i < 18; i++)     conv_beat(1'b1, 1'b0, i);
        for (int i = 18; i < NCONV; i++) conv_beat(1'b0, 1'b1, i);
    endtask

    task automatic finish_check();
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 1);
        chk("fin_weight_fc_in", weight_fc_in, NFC - 1);
        @(posedge clk); #1;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        we0 = 1'b0;
        we1 = 1'b0;
        fc_ivalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        // Load 1: dual-enable beats, a gap with illegal fc_ivalid and a
        // start-while-busy, then the rest of conv and the full FC stream.
        start_load();
        for (int i = 0; i < 4; i++)  conv_beat(1'b1, 1'b1, i);
        for (int i = 4; i < 18; i++) conv_beat(1'b1, 1'b0, i);
        fc_ivalid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("conv_gap_fc_mem_rd", fc_mem_rd, 0);
        chk("conv_gap_conv_mem_rd", conv_mem_rd, 0);
        @(posedge clk); #1;
        fc_ivalid = 1'b0;
        start = 1'b0;
        chk("conv_gap_hold_bit", weight_conv_in, 1);
        chk("conv_gap_fc_unchanged", weight_fc_in, 0);
        chk("conv_gap_err", err, ERR_ON);
        chk("conv_gap_busy", busy, 1);
        for (int i = 18; i < NCONV; i++) conv_beat(1'b0, 1'b1, i);

        chk("in_fc_busy", busy, 1);
        chk("in_fc_done", done, 0);
        we0 = 1'b1;
        @(negedge clk);
        chk("fc_conv_req_no_rd", conv_mem_rd, 0);
        @(posedge clk); #1;
        we0 = 1'b0;
        chk("fc_conv_req_hold", weight_conv_in, 0);

        for (int k = 0; k < NFC; k++) fc_beat(k);
        finish_check();
        chk("load1_err_sticky", err, ERR_ON);

        // Load 2: abort with reset at fc_cnt = 100.
        start_load();
        conv_load();
        for (int k = 0; k < 100; k++) fc_beat(k);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_outputs();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
        end
        sb.delete();
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);

        // Load 3: full clean load from address 0.
        start_load();
        conv_load();
        for (int k = 0; k < NFC; k++) fc_beat(k);
        finish_check();
        chk("load3_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bnn_weight_sched.md
BNN_WEIGHT_SCHED -- requirements
Module: bnn_weight_sched

Interface
REQ-001 SHALL have parameter CONV1_BITS, default 18, meaning number of conv1 weight bits.
REQ-002 SHALL have parameter CONV2_BITS, default 288, meaning number of conv2 weight bits.
REQ-003 SHALL have parameter FC_DEPTH, default 256, meaning number of FC weight words, each 10 bits with one bit per class lane.
REQ-004 SHALL have parameters CAW, default 9, and FAW, default 8, meaning the conv and FC memory address widths.
REQ-005 Ports SHALL be, clock and reset first:
 clk  in  1  single clock, rising edge;
 rstn  in  1  asynchronous active-low reset;
 start  in  1  begin a weight load;
 weight_en_0  in  1  accelerator requests a conv weight bit, phase 0;
 weight_en_1  in  1  accelerator requests a conv weight bit, phase 1;
 fc_ivalid  in  1  accelerator consumes one FC word;
 conv_mem_rd  out  1  conv ROM read strobe;
 conv_mem_addr  out  CAW  conv ROM address;
 conv_mem_rdata  in  1  conv ROM data, one-cycle latency;
 fc_mem_rd  out  1  FC ROM read strobe;
 fc_mem_addr  out  FAW  FC ROM address;
 fc_mem_rdata  in  10  FC ROM data, one-cycle latency;
 weight_conv_in  out  1  conv weight bit to the accelerator;
 weight_fc_in  out  10  FC weight bits, bit k goes to class k;
 busy  out  1  load in progress;
 done  out  1  one-cycle pulse at the end of the load;
 err  out  1  sticky protocol error.

Function
REQ-006 The FSM SHALL have states IDLE, CONV, FC and FIN.
REQ-007 IDLE SHALL go to CONV when start is sampled high, clearing conv_cnt, fc_cnt and err.
REQ-008 In CONV, each cycle with (weight_en_0 | weight_en_1) SHALL consume exactly one bit; if both are high, one bit is consumed.
REQ-009 The consumed bit SHALL be ROM address conv_cnt; addresses 0..CONV1_BITS-1 are conv1 and CONV1_BITS..CONV1_BITS+CONV2_BITS-1 are conv2; conv_mem_rd SHALL equal the consume condition.
REQ-010 weight_conv_in SHALL show the consumed bit in the cycle after the request and SHALL hold it until the next consume.
REQ-011 After the consume with conv_cnt = CONV1_BITS+CONV2_BITS-1, the FSM SHALL go to FC.
REQ-012 In FC, each cycle with fc_ivalid SHALL read fc_mem_addr = fc_cnt; weight_fc_in SHALL be valid in the next cycle and held until the next read.
REQ-013 After the read with fc_cnt = FC_DEPTH-1, the FSM SHALL go to FIN; FIN SHALL pulse done for one cycle and then return to IDLE.
REQ-014 busy SHALL be 1 in CONV, FC and FIN.
REQ-015 start while busy SHALL be ignored.
REQ-016 Counters SHALL never wrap; no read SHALL occur beyond the final address.
REQ-017 A conv request outside CONV, or fc_ivalid outside FC, SHALL issue no read, leave outputs unchanged and set err.

Reset
REQ-018 While rstn=0, the FSM SHALL be IDLE, all counters 0, and weight_conv_in, weight_fc_in, conv_mem_rd, fc_mem_rd, busy, done and err 0, with effect immediate and independent of clk.
REQ-019 Reset during a load SHALL abort it; no done SHALL follow, and a new start is required.

Configuration
REQ-020 With macro BNN_WSCHED_ERR_EN defined, REQ-017 err detection SHALL be present.
REQ-021 Without BNN_WSCHED_ERR_EN, err SHALL be tied to 0, with out-of-state requests still ignored.

Structure
REQ-022 Shared package bnn_pkg SHALL hold the FSM state enum, class-lane count 10, and default CONV1_BITS, CONV2_BITS and FC_DEPTH.
REQ-023 A single sub-module bnn_addr_ctr SHALL implement an address counter with clear, increment and last-flag, instantiated twice (conv and FC).

Verification
REQ-024 start=1, then 18 weight_en_0 cycles with conv1 ROM=1 and 288 weight_en_1 cycles with conv2 ROM=0 -> conv_mem_addr 0..305, weight_conv_in 1 for 18 beats then 0, FSM in FC, done=0.
REQ-025 fc_ivalid for 256 cycles with ROM word = address[9:0] -> weight_fc_in = k in the cycle after the k-th read, done high one cycle after the last, busy=0 thereafter.
REQ-026 weight_en_0=weight_en_1=1 for 4 cycles -> conv_cnt advances by exactly 4.
REQ-027 fc_ivalid pulse during CONV -> fc_mem_rd=0, weight_fc_in unchanged, err=1 with BNN_WSCHED_ERR_EN and 0 without.
REQ-028 rstn low mid-FC at fc_cnt=100 -> all outputs 0 immediately, no done; a new start runs a full load from address 0.
